// File: rtl/svm_pkg.sv
// Shared definitions for the SVM front-end blocks: frame geometry, pixel type
// and the image loader state encoding.
package svm_pkg;

  localparam int unsigned IMG_SIZE    = 784;
  localparam int unsigned PIXEL_WIDTH = 16;

  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_PAD       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_START     = 3'd4,
    ST_WAIT_BUSY = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_DONE      = 3'd7
  } loader_state_e;

endpackage

// File: rtl/loader_fsm.sv
// Image loader control FSM: state register and next-state logic.
// The datapath (pixel counter, error flags, BRAM mux) lives in image_loader.
module loader_fsm (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  input  logic                   s_last,
  input  logic                   beat,
  input  logic                   cnt_last,
  input  logic                   dskw_ready,
  output svm_pkg::loader_state_e state
);

  import svm_pkg::*;

  loader_state_e state_d;

  // State register; reset mid-frame abandons the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: load, pad a short frame or drain a long one, then run Deskew.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:      if (s_valid && dskw_ready) state_d = ST_LOAD;
      ST_LOAD: begin
        if (beat) begin
          if (cnt_last)    state_d = s_last ? ST_START : ST_DRAIN;
          else if (s_last) state_d = ST_PAD;
        end
      end
      ST_PAD:       if (cnt_last) state_d = ST_START;
      ST_DRAIN:     if (beat && s_last) state_d = ST_START;
      ST_START:     if (!dskw_ready) state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (dskw_ready) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/image_loader.sv
// Image loader: takes one frame as a valid/ready pixel stream, writes it into
// BRAM port A starting at BASE_ADDR, then starts Deskew and reports completion.
// Optional feature macro LOADER_CHECKSUM_EN adds a 32-bit running sum of the
// pixels written during LOAD on port 'checksum'.
module image_loader #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned IMG_SIZE   = svm_pkg::IMG_SIZE,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  en,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WIDTH-1:0]      out_data,
  output logic                  dskw_start,
  input  logic                  dskw_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_short,
  output logic                  err_long
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  import svm_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = ADDR_WIDTH'(IMG_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);

  if (64'(BASE_ADDR) + 64'(IMG_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_cfg_check
    $error("image_loader: BASE_ADDR + IMG_SIZE exceeds the BRAM address space");
  end

  loader_state_e         state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  beat;
  logic                  cnt_last;
  logic                  frame_start;

  assign beat        = s_valid && s_ready;
  assign cnt_last    = (cnt == CNT_MAX);
  assign frame_start = (state == ST_IDLE) && s_valid && dskw_ready;

  loader_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .beat       (beat),
    .cnt_last   (cnt_last),
    .dskw_ready (dskw_ready),
    .state      (state)
  );

  // Pixel counter: advances per written address, saturates on the last pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (frame_start) begin
      cnt <= '0;
    end else if (((state == ST_LOAD && beat) || state == ST_PAD) && !cnt_last) begin
      cnt <= cnt + ADDR_WIDTH'(1);
    end
  end

  // Frame length errors, sticky until the next frame begins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (frame_start) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else if (state == ST_LOAD && beat) begin
      if (cnt_last && !s_last) err_long <= 1'b1;
      if (!cnt_last && s_last) err_short <= 1'b1;
    end
  end

  // BRAM port A is driven only in LOAD/PAD so Deskew owns it otherwise.
  always_comb begin
    en       = 1'b0;
    we       = 1'b0;
    address  = '0;
    out_data = '0;
    case (state)
      ST_LOAD: begin
        en       = beat;
        we       = beat;
        address  = BASE + cnt;
        out_data = s_data;
      end
      ST_PAD: begin
        en       = 1'b1;
        we       = 1'b1;
        address  = BASE + cnt;
        out_data = '0;
      end
      default: ;
    endcase
  end

  // Stream handshake and status outputs decoded from the state.
  always_comb begin
    s_ready    = (state == ST_LOAD) || (state == ST_DRAIN);
    dskw_start = (state == ST_START);
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of accepted pixels; padding zeros contribute nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum <= '0;
    end else if (frame_start) begin
      checksum <= '0;
    end else if (state == ST_LOAD && beat) begin
      checksum <= checksum + 32'(s_data);
    end
  end
`endif

endmodule

// File: tb/tb_image_loader.sv
// Directed testbench for image_loader: table of frame scenarios plus
// hand-written reset and start-gating sequences, with a BRAM model.
module tb_image_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        en;
  logic        we;
  logic [10:0] address;
  logic [15:0] out_data;
  logic        dskw_start;
  logic        dskw_ready;
  logic        busy;
  logic        done;
  logic        err_short;
  logic        err_long;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  image_loader #(
    .WIDTH      (16),
    .ADDR_WIDTH (11),
    .IMG_SIZE   (784),
    .BASE_ADDR  (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .en         (en),
    .we         (we),
    .address    (address),
    .out_data   (out_data),
    .dskw_start (dskw_start),
    .dskw_ready (dskw_ready),
    .busy       (busy),
    .done       (done),
    .err_short  (err_short),
    .err_long   (err_long)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int nbeats;
    int last_idx;
    bit toggle;
    int mode;
    bit exp_short;
    bit exp_long;
  } vec_t;

  vec_t        vecs[5];
  logic [15:0] mem[0:783];
  int          wr_cnt;
  int          viol;
  int          checks;
  int          failures;

  // BRAM model and port-A protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (en || we) begin
      wr_cnt++;
      if (en != we) viol++;
      if (s_ready && !s_valid) viol++;
      if (address >= 11'd784) viol++;
      else mem[address] = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int mode, input int i);
    logic [31:0] v;
    case (mode)
      0:       v = 32'(i);
      1:       v = 32'(i) * 32'd37 + 32'h1234;
      default: v = 32'hFFFF;
    endcase
    return v[15:0];
  endfunction

  // Feed beats 0..stop-1 of a frame; returns the number actually accepted.
  task automatic feed(input int stop, input int last_idx, input bit toggle,
                      input int mode, output int accepted);
    int i;
    int guard;
    bit ph;
    i = 0;
    guard = 0;
    ph = 1'b0;
    while (i < stop && guard < 5000) begin
      s_data  = pix(mode, i);
      s_last  = (i == last_idx);
      s_valid = !(toggle && ph);
      if (s_valid && s_ready) i++;
      ph = !ph;
      guard++;
      tick();
    end
    accepted = i;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int          got;
    int          guard;
    int          mism;
    int          nload;
    logic [15:0] e;
    logic [31:0] exp_sum;
    for (int a = 0; a < 784; a++) mem[a] = 16'hDEAD;
    wr_cnt = 0;
    viol   = 0;
    dskw_ready = 1'b1;

    feed(v.nbeats, v.last_idx, v.toggle, v.mode, got);
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    check({tag, "_beats_accepted"}, 32'(got), 32'(v.nbeats));

    guard = 0;
    while (!dskw_start && guard < 2000) begin
      tick();
      guard++;
    end
    check({tag, "_start_seen"}, {31'd0, dskw_start}, 32'd1);

    mism = 0;
    for (int a = 0; a < 784; a++) begin
      e = (a <= v.last_idx) ? pix(v.mode, a) : 16'h0000;
      if (mem[a] !== e) mism++;
    end
    check({tag, "_bram_mismatches"}, 32'(mism), 32'd0);
    check({tag, "_write_count"}, 32'(wr_cnt), 32'd784);
    check({tag, "_port_violations"}, 32'(viol), 32'd0);
    check({tag, "_err_short"}, {31'd0, err_short}, {31'd0, v.exp_short});
    check({tag, "_err_long"}, {31'd0, err_long}, {31'd0, v.exp_long});

    repeat (3) tick();
    check({tag, "_start_held"}, {31'd0, dskw_start}, 32'd1);
    check({tag, "_busy_in_start"}, {31'd0, busy}, 32'd1);

    dskw_ready = 1'b0;
    tick();
    check({tag, "_start_dropped"}, {31'd0, dskw_start}, 32'd0);
    repeat (4) tick();
    check({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_waiting"}, {31'd0, busy}, 32'd1);
    check({tag, "_no_bram_while_running"}, 32'(wr_cnt), 32'd784);

    dskw_ready = 1'b1;
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd1);
`ifdef LOADER_CHECKSUM_EN
    nload = (v.last_idx < 783) ? v.last_idx + 1 : 784;
    exp_sum = '0;
    for (int a = 0; a < nload; a++) exp_sum = exp_sum + 32'(pix(v.mode, a));
    check({tag, "_checksum"}, checksum, exp_sum);
    if (v.mode == 2) check({tag, "_checksum_ffff"}, checksum, 32'h030F_FCF0);
`else
    nload = 0;
    exp_sum = '0;
`endif
    tick();
    check({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_err_held"}, {30'd0, err_short, err_long},
          {30'd0, v.exp_short, v.exp_long});
  endtask

  initial begin
    int got;
    checks   = 0;
    failures = 0;
    wr_cnt   = 0;
    viol     = 0;

    vecs[0] = '{nbeats: 784, last_idx: 783, toggle: 1'b0, mode: 0, exp_short: 1'b0, exp_long: 1'b0};
    vecs[1] = '{nbeats: 10,  last_idx: 9,   toggle: 1'b0, mode: 1, exp_short: 1'b1, exp_long: 1'b0};
    vecs[2] = '{nbeats: 800, last_idx: 799, toggle: 1'b0, mode: 1, exp_short: 1'b0, exp_long: 1'b1};
    vecs[3] = '{nbeats: 784, last_idx: 783, toggle: 1'b1, mode: 0, exp_short: 1'b0, exp_long: 1'b0};
    vecs[4] = '{nbeats: 784, last_idx: 783, toggle: 1'b0, mode: 2, exp_short: 1'b0, exp_long: 1'b0};

    reset      = 1'b0;
    s_data     = '0;
    s_valid    = 1'b0;
    s_last     = 1'b0;
    dskw_ready = 1'b1;
    repeat (2) tick();
    check("rst_outputs",
          {21'd0, s_ready, en, we, dskw_start, busy, done, err_short, err_long, 3'd0},
          32'd0);
    check("rst_address", {21'd0, address}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    reset = 1'b1;
    tick();
    check("idle_not_ready", {31'd0, s_ready}, 32'd0);

    // Deskew not idle: the loader must not start a frame.
    dskw_ready = 1'b0;
    s_valid    = 1'b1;
    repeat (3) tick();
    check("gated_by_dskw_ready", {30'd0, busy, s_ready}, 32'd0);
    s_valid    = 1'b0;
    dskw_ready = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) run_frame(vecs[k], $sformatf("v%0d", k));

    // Reset in the middle of LOAD, then a clean frame.
    feed(400, 783, 1'b0, 1, got);
    check("abort_beats", 32'(got), 32'd400);
    check("abort_in_load", {31'd0, s_ready}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_outputs",
          {21'd0, s_ready, en, we, dskw_start, busy, done, err_short, err_long, 3'd0},
          32'd0);
    check("abort_address", {21'd0, address}, 32'd0);
    check("abort_out_data", {16'd0, out_data}, 32'd0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_frame(vecs[0], "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
